// File: rtl/sccomp_dbg_pkg.sv
// Shared types and defaults for the sccomp run/debug controller.
// The state encoding is fixed so a checker or probe can decode it.
package sccomp_dbg_pkg;

   localparam int RF_AW = 5;
   localparam int RF_DW = 32;

   localparam logic [31:0] DEF_HALT_PC    = 32'h0000_0048;
   localparam int          DEF_MAX_CYCLES = 1000;
   localparam int          DEF_NREG       = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RST_CPU = 3'd1,
      ST_RUN     = 3'd2,
      ST_DUMP    = 3'd3,
      ST_DONE    = 3'd4
   } run_state_e;

endpackage

// File: rtl/sccomp_run_ctrl.sv
// Run controller for sccomp: resets the CPU, steps it until the halt PC or a
// cycle budget is reached, then streams the register file out.
//
// Dump port handshake: a word transfers on a rising edge where dump_valid and
// dump_ready are both 1; while dump_ready is 0, dump_idx and dump_data hold.
module sccomp_run_ctrl
   import sccomp_dbg_pkg::*;
#(
   parameter logic [31:0] HALT_PC    = DEF_HALT_PC,
   parameter int          MAX_CYCLES = DEF_MAX_CYCLES,
   parameter int          NREG       = DEF_NREG,
   parameter int          CW         = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 abort,
   input  logic [31:0]          cpu_pc,
   output logic                 cpu_rstn,
   output logic                 cpu_en,
   output logic [RF_AW-1:0]     rf_raddr,
   input  logic [RF_DW-1:0]     rf_rdata,
   output logic                 dump_valid,
   input  logic                 dump_ready,
   output logic [RF_AW-1:0]     dump_idx,
   output logic [RF_DW-1:0]     dump_data,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout,
   output logic [CW-1:0]        cycle_count
);

   localparam logic [CW-1:0]    MAX_CC   = CW'(MAX_CYCLES);
   localparam logic [RF_AW-1:0] LAST_IDX = RF_AW'(NREG - 1);

   run_state_e       state_q, state_d;
   logic             rst_cnt_q, rst_cnt_d;
   logic [CW-1:0]    cycle_count_q, cycle_count_d;
   logic             timeout_q, timeout_d;
   logic [RF_AW-1:0] dump_idx_q, dump_idx_d;

   logic at_halt;
   logic at_budget;
   logic run_en;

   assign at_halt   = (cpu_pc == HALT_PC);
   assign at_budget = (cycle_count_q == MAX_CC);
   // abort gates the step enable in the same cycle it is seen
   assign run_en    = (state_q == ST_RUN) && !at_halt && !at_budget && !abort;

   always_comb begin
      state_d       = state_q;
      rst_cnt_d     = rst_cnt_q;
      cycle_count_d = cycle_count_q;
      timeout_d     = timeout_q;
      dump_idx_d    = dump_idx_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d       = ST_RST_CPU;
               rst_cnt_d     = 1'b0;
               cycle_count_d = '0;
               timeout_d     = 1'b0;
               dump_idx_d    = '0;
            end
         end
         ST_RST_CPU: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (rst_cnt_q) begin
               state_d = ST_RUN;
            end else begin
               rst_cnt_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (run_en) begin
               cycle_count_d = cycle_count_q + CW'(1);
            end
            // halt is checked before the budget so a halt on the last cycle is not a timeout
            if (abort) begin
               state_d = ST_IDLE;
            end else if (at_halt) begin
               state_d   = ST_DUMP;
               timeout_d = 1'b0;
            end else if (at_budget) begin
               state_d   = ST_DUMP;
               timeout_d = 1'b1;
            end
         end
         ST_DUMP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (dump_ready) begin
               if (dump_idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  dump_idx_d = dump_idx_q + RF_AW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         rst_cnt_q     <= 1'b0;
         cycle_count_q <= '0;
         timeout_q     <= 1'b0;
         dump_idx_q    <= '0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         cycle_count_q <= cycle_count_d;
         timeout_q     <= timeout_d;
         dump_idx_q    <= dump_idx_d;
      end
   end

   assign cpu_rstn    = (state_q == ST_RUN) || (state_q == ST_DUMP) || (state_q == ST_DONE);
   assign cpu_en      = run_en;
   assign rf_raddr    = (state_q == ST_DUMP) ? dump_idx_q : '0;
   assign dump_valid  = (state_q == ST_DUMP);
   assign dump_idx    = dump_idx_q;
   // register 0 is architecturally zero regardless of what the RF port returns
   assign dump_data   = (dump_idx_q == '0) ? '0 : rf_rdata;
   assign busy        = (state_q == ST_RST_CPU) || (state_q == ST_RUN) || (state_q == ST_DUMP);
   assign done        = (state_q == ST_DONE);
   assign timeout     = timeout_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: doc/sccomp_run_ctrl.md
Name: sccomp_run_ctrl

Overview:
Hardware run/sequencing controller for the single-cycle CPU system (sccomp).
- Holds the CPU in reset, releases it on a start pulse, then steps it with a clock-enable.
- Stops the CPU when PC reaches a halt address or a cycle budget is exhausted.
- Then streams the full register file out over a valid/ready port.
- Sits beside sccomp; drives the CPU reset, step enable and the RF debug read port.

Parameters:
HALT_PC, 32'h0000_0048, PC value that ends a run (CPU is not stepped at this PC)
MAX_CYCLES, 1000, maximum enabled CPU cycles per run before timeout
NREG, 32, number of register-file entries dumped
CW, 16, width of cycle counter (must hold MAX_CYCLES)

Ports:
clk  in  1  system clock, all state on rising edge
rstn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
abort  in  1  level; cancels a run or dump, returns to IDLE
cpu_pc  in  32  current CPU PC
cpu_rstn  out  1  CPU reset, active-low
cpu_en  out  1  CPU step enable (PC/RF/DM update only when 1)
rf_raddr  out  5  RF debug read address
rf_rdata  in  32  RF debug read data, combinational from rf_raddr
dump_valid  out  1  dump word available
dump_ready  in  1  consumer accepts dump word
dump_idx  out  5  register index of current dump word
dump_data  out  32  register value (forced 0 for index 0)
busy  out  1  state is RST_CPU, RUN or DUMP
done  out  1  state is DONE
timeout  out  1  last run ended by MAX_CYCLES (sticky until next start)
cycle_count  out  CW  enabled cycles in current/last run

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-low. When rstn=0 at a rising edge: state=IDLE, dump_idx=0, cycle_count=0, timeout=0, rst_cnt=0.
  - Resulting outputs: cpu_rstn=0, cpu_en=0, dump_valid=0, busy=0, done=0, rf_raddr=0.
  - Reset mid-run or mid-dump behaves the same; no partial dump continues.
- States: IDLE, RST_CPU, RUN, DUMP, DONE.
- IDLE: cpu_rstn=0, cpu_en=0. start=1 -> RST_CPU; clear cycle_count, timeout, dump_idx.
- RST_CPU:
  - cpu_rstn=0 for exactly 2 cycles (internal 1-bit counter), then -> RUN.
  - Start pulse at edge t gives first RUN cycle at t+3.
- RUN:
  - cpu_rstn=1.
  - cpu_en is combinational: (cpu_pc != HALT_PC) && (cycle_count != MAX_CYCLES) && !abort.
  - cycle_count increments on each edge where cpu_en=1; it never exceeds MAX_CYCLES.
  - If cpu_pc==HALT_PC: -> DUMP, timeout=0. Halt takes priority when both conditions are true in the same cycle.
  - Else if cycle_count==MAX_CYCLES: -> DUMP, timeout=1.
- DUMP:
  - cpu_rstn=1, cpu_en=0, so CPU state is frozen and the RF is preserved.
  - rf_raddr=dump_idx; dump_valid=1; dump_data = (dump_idx==0) ? 0 : rf_rdata.
  - On dump_valid && dump_ready: if dump_idx==NREG-1 -> DONE, else dump_idx+1.
  - While dump_ready=0, dump_idx and dump_data stay stable.
  - First dump word is valid in the first DUMP cycle.
- DONE:
  - cpu_rstn=1, cpu_en=0, done=1.
  - cycle_count and timeout are held for readback.
  - start=1 -> RST_CPU (new run).
- abort:
  - In RST_CPU, RUN or DUMP: -> IDLE next edge; cpu_en=0 in the same cycle.
  - timeout and cycle_count are held.
  - abort has priority over start, halt and handshake.
- start outside IDLE/DONE is ignored.
- start and abort in the same cycle in IDLE/DONE: abort wins, stay or go to IDLE.
- Width rules:
  - cycle_count is unsigned CW bits and compared against MAX_CYCLES as CW bits.
  - dump_idx is 5 bits; NREG-1 is at most 31.
- cpu_pc is compared bitwise; unknown values are not interpreted.

Decomposition:
- Package sccomp_dbg_pkg holds:
  - the state enum (IDLE, RST_CPU, RUN, DUMP, DONE);
  - default HALT_PC, MAX_CYCLES and NREG constants;
  - the RF address width (5) and data width (32).
- Single module; no sub-module required. The cycle counter stays inline.

Test Plan:
- Halt path: stub CPU with PC += 4 per enabled cycle from 0; pulse start -> cpu_rstn low for 2 cycles; cpu_en high for 18 cycles; cpu_en=0 when PC=0x48; cycle_count=18, timeout=0; 32 words dumped with idx 0..31, word0=0; then done=1.
- Timeout path: PC stuck at 0x10 -> exactly 1000 cpu_en cycles, cycle_count=1000, timeout=1, dump follows, done=1.
- Backpressure: RF preloaded rf[i]=0x1000+i; dump_ready toggles 1,0,0,1 -> each idx presented exactly once in order; data stable while ready=0; rf[5] read as 0x00001005; idx0 reads 0 even if rf[0]=0xFFFFFFFF.
- Abort mid-run at cycle 7 -> cpu_en=0 that cycle, IDLE next edge, cpu_rstn=0, cycle_count=7, no dump_valid.
- Reset during dump at idx 12 -> next edge all outputs at reset values; a following start gives a fresh run with dump from idx 0.
- start pulses in RUN and DUMP are ignored (no restart, cycle_count unaffected); start in DONE begins a new run with cycle_count cleared to 0.
